// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcode/funct constants, divider states and helpers for the execute stage
package ex_pkg;

  localparam int INST_W     = 32;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [REG_W-1:0] neg_if(input logic neg, input logic [REG_W-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative restoring divider for DIV/DIVU/REM/REMU with special-case bypass
module ex_div
  import ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_rem,
  input  logic [REG_W-1:0] op_a,
  input  logic [REG_W-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [REG_W-1:0] result
);

  localparam int CW = $clog2(DIV_STEPS);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [REG_W-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic             rem_neg_q, quo_neg_q, is_rem_q;
  logic             load, step;

  logic             a_neg, b_neg, div_zero, overflow, special;
  logic [REG_W-1:0] special_res;
  logic [REG_W:0]   rem_sh, diff;
  logic             q_bit;

  assign a_neg    = is_signed & op_a[REG_W-1];
  assign b_neg    = is_signed & op_b[REG_W-1];
  assign div_zero = (op_b == '0);
  assign overflow = is_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign special  = div_zero || overflow;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? op_a : 32'hFFFF_FFFF;
    else if (overflow)
      special_res = is_rem ? 32'h0 : 32'h8000_0000;
  end

  // One restoring step: 33 bits hold the shifted partial remainder even for unsigned divisors above 2^31.
  assign rem_sh = {rem_q, dvd_q[REG_W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign q_bit  = ~diff[REG_W];

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    result  = '0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          if (special) begin
            done   = 1'b1;
            result = special_res;
          end else begin
            busy    = 1'b1;
            load    = 1'b1;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (count_q == CW'(DIV_STEPS - 1))
          state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done    = 1'b1;
        result  = is_rem_q ? neg_if(rem_neg_q, rem_q) : neg_if(quo_neg_q, quo_q);
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      rem_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        dvd_q     <= neg_if(a_neg, op_a);
        dvs_q     <= neg_if(b_neg, op_b);
        rem_q     <= '0;
        quo_q     <= '0;
        count_q   <= '0;
        rem_neg_q <= a_neg;
        quo_neg_q <= a_neg ^ b_neg;
        is_rem_q  <= is_rem;
      end else if (step) begin
        dvd_q   <= {dvd_q[REG_W-2:0], 1'b0};
        rem_q   <= q_bit ? diff[REG_W-1:0] : rem_sh[REG_W-1:0];
        quo_q   <= {quo_q[REG_W-2:0], q_bit};
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex.sv
// rtl/ex.sv - RV32IM execute stage: ALU, single-cycle multiplier, divider wrapper and hold request
module ex
  import ex_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [INST_W-1:0]     inst_i,
  input  logic [REG_W-1:0]      instaddr_i,
  input  logic [REG_W-1:0]      op1_i,
  input  logic [REG_W-1:0]      op2_i,
  input  logic                  regs_wen_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_W-1:0]      rd_wdata_o,
  output logic                  regs_wen_o,
  output logic [REG_W-1:0]      instaddr_o,
  output logic                  hold_req_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] shamt;
  logic       is_op, is_muldiv, is_div;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign funct7    = inst_i[31:25];
  assign shamt     = op2_i[4:0];
  assign is_op     = (opcode == OPC_OP);
  assign is_muldiv = is_op && (funct7 == F7_MULDIV);
  assign is_div    = is_muldiv && funct3[2];

  // 33x33 signed product covers all four multiply flavours via per-operand extension.
  logic signed [REG_W:0]     mul_a, mul_b;
  logic signed [2*REG_W+1:0] mul_p;
  logic [REG_W-1:0]          mul_res;
  logic                      a_sext, b_sext;

  assign a_sext  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
  assign b_sext  = (funct3 == F3_MULH);
  assign mul_a   = {a_sext & op1_i[REG_W-1], op1_i};
  assign mul_b   = {b_sext & op2_i[REG_W-1], op2_i};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (funct3 == F3_MUL) ? mul_p[REG_W-1:0] : mul_p[2*REG_W-1:REG_W];

  logic             div_busy, div_done;
  logic [REG_W-1:0] div_result;

  ex_div #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .start     (rstn && is_div),
    .is_signed (~funct3[0]),
    .is_rem    (funct3[1]),
    .op_a      (op1_i),
    .op_b      (op2_i),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  logic [REG_W-1:0] alu_res;
  logic             known;

  always_comb begin
    alu_res = '0;
    known   = 1'b1;
    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        if (is_op && !(funct7 == F7_BASE || funct7 == F7_ALT || funct7 == F7_MULDIV)) begin
          known = 1'b0;
        end else if (is_muldiv) begin
          if (is_div)
            alu_res = div_done ? div_result : '0;
          else
            alu_res = mul_res;
        end else begin
          case (funct3)
            F3_ADD:  alu_res = (is_op && funct7[5]) ? op1_i - op2_i : op1_i + op2_i;
            F3_SLL:  alu_res = op1_i << shamt;
            F3_SLT:  alu_res = {31'b0, $signed(op1_i) < $signed(op2_i)};
            F3_SLTU: alu_res = {31'b0, op1_i < op2_i};
            F3_XOR:  alu_res = op1_i ^ op2_i;
            F3_SR:   alu_res = funct7[5] ? REG_W'($signed(op1_i) >>> shamt) : op1_i >> shamt;
            F3_OR:   alu_res = op1_i | op2_i;
            F3_AND:  alu_res = op1_i & op2_i;
            default: alu_res = '0;
          endcase
        end
      end
      OPC_LUI:   alu_res = op1_i + op2_i;
      OPC_AUIPC: alu_res = instaddr_i + op2_i;
      default:   known = 1'b0;
    endcase
  end

  assign hold_req_o = rstn && div_busy;
  assign regs_wen_o = rstn && regs_wen_i && known && !div_busy;
  assign rd_wdata_o = (rstn && known) ? alu_res : '0;
  assign rd_addr_o  = rstn ? rd_addr_i : '0;
  assign instaddr_o = rstn ? instaddr_i : '0;

  // Register-field bits are consumed by decode upstream; operands arrive already resolved.
  logic unused_bits;
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7], mul_p[2*REG_W+1:2*REG_W]};

endmodule

// File: tb/tb_ex.sv
// tb/tb_ex.sv - scoreboard testbench for the ex execute stage
module tb_ex;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] inst_i, instaddr_i, op1_i, op2_i;
  logic        regs_wen_i;
  logic [4:0]  rd_addr_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o, instaddr_o;
  logic        regs_wen_o, hold_req_o;

  always #5 clk = ~clk;

  ex #(.DIV_STEPS(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .inst_i     (inst_i),
    .instaddr_i (instaddr_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .regs_wen_i (regs_wen_i),
    .rd_addr_i  (rd_addr_i),
    .rd_addr_o  (rd_addr_o),
    .rd_wdata_o (rd_wdata_o),
    .regs_wen_o (regs_wen_o),
    .instaddr_o (instaddr_o),
    .hold_req_o (hold_req_o)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd0, f3, rd, 7'b0010011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (hold_req_o)
      check("wen_during_hold", {31'b0, regs_wen_o}, 32'd0);
    if (regs_wen_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: rd %0d data %h expected no write", rd_addr_o, rd_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("rd_addr", {27'b0, rd_addr_o}, {27'b0, e.rd});
        check("rd_wdata", rd_wdata_o, e.data);
        check("instaddr", instaddr_o, e.addr);
      end
    end
  end

  task automatic do_op(input string name, input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] addr, input logic [4:0] rd,
                       input logic wen_exp, input logic [31:0] data, input int hold_exp);
    int n;
    exp_t e;
    @(posedge clk); #1;
    inst_i = inst; op1_i = a; op2_i = b; instaddr_i = addr; rd_addr_i = rd; regs_wen_i = 1'b1;
    if (wen_exp) begin
      e.rd = rd; e.data = data; e.addr = addr;
      exp_q.push_back(e);
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!hold_req_o) break;
      n++;
    end
    check({name, "_hold_cycles"}, 32'(n), 32'(hold_exp));
    if (!wen_exp) begin
      check({name, "_wen"}, {31'b0, regs_wen_o}, 32'd0);
      check({name, "_wdata"}, rd_wdata_o, 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    inst_i = rtype(7'b0000001, 3'b100, 5'd5);
    op1_i = 32'd7; op2_i = 32'd2; instaddr_i = 32'h100; rd_addr_i = 5'd5; regs_wen_i = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hold", {31'b0, hold_req_o}, 32'd0);
    check("reset_wen", {31'b0, regs_wen_o}, 32'd0);
    check("reset_wdata", rd_wdata_o, 32'd0);
    check("reset_rd", {27'b0, rd_addr_o}, 32'd0);
    check("reset_instaddr", instaddr_o, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; inst_i = NOP; regs_wen_i = 1'b0;

    do_op("addi", 32'hFFB0_0093, 32'h0, 32'hFFFF_FFFB, 32'h200, 5'd1, 1'b1, 32'hFFFF_FFFB, 0);
    do_op("sub", rtype(7'b0100000, 3'b000, 5'd3), 32'd5, 32'd7, 32'h204, 5'd3, 1'b1, 32'hFFFF_FFFE, 0);
    do_op("sll", rtype(7'b0, 3'b001, 5'd4), 32'd1, 32'h21, 32'h208, 5'd4, 1'b1, 32'd2, 0);
    do_op("sra", rtype(7'b0100000, 3'b101, 5'd5), 32'h8000_0000, 32'd4, 32'h20C, 5'd5, 1'b1, 32'hF800_0000, 0);
    do_op("srli", itype(12'h004, 3'b101, 5'd5), 32'h8000_0000, 32'd4, 32'h210, 5'd5, 1'b1, 32'h0800_0000, 0);
    do_op("slt", rtype(7'b0, 3'b010, 5'd6), 32'hFFFF_FFFF, 32'd1, 32'h214, 5'd6, 1'b1, 32'd1, 0);
    do_op("sltu", rtype(7'b0, 3'b011, 5'd6), 32'hFFFF_FFFF, 32'd1, 32'h218, 5'd6, 1'b1, 32'd0, 0);
    do_op("xor", rtype(7'b0, 3'b100, 5'd7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h21C, 5'd7, 1'b1, 32'h0FF0_0FF0, 0);
    do_op("or", rtype(7'b0, 3'b110, 5'd7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h220, 5'd7, 1'b1, 32'hFFF0_FFF0, 0);
    do_op("and", rtype(7'b0, 3'b111, 5'd7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h224, 5'd7, 1'b1, 32'hF000_F000, 0);
    do_op("lui", 32'h1234_5437, 32'h0, 32'h1234_5000, 32'h228, 5'd8, 1'b1, 32'h1234_5000, 0);
    do_op("auipc", 32'h0000_2497, 32'h0, 32'h0000_2000, 32'h1000, 5'd9, 1'b1, 32'h0000_3000, 0);
    do_op("mul", rtype(7'b1, 3'b000, 5'd10), 32'd7, 32'hFFFF_FFFD, 32'h230, 5'd10, 1'b1, 32'hFFFF_FFEB, 0);
    do_op("mulh", rtype(7'b1, 3'b001, 5'd10), 32'h8000_0000, 32'h8000_0000, 32'h234, 5'd10, 1'b1, 32'h4000_0000, 0);
    do_op("mulhsu", rtype(7'b1, 3'b010, 5'd10), 32'hFFFF_FFFF, 32'd2, 32'h238, 5'd10, 1'b1, 32'hFFFF_FFFF, 0);
    do_op("mulhu", rtype(7'b1, 3'b011, 5'd10), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h23C, 5'd10, 1'b1, 32'hFFFF_FFFE, 0);
    do_op("div", rtype(7'b1, 3'b100, 5'd11), 32'hFFFF_FFF9, 32'd2, 32'h240, 5'd11, 1'b1, 32'hFFFF_FFFD, 33);
    do_op("rem", rtype(7'b1, 3'b110, 5'd11), 32'hFFFF_FFF9, 32'd2, 32'h244, 5'd11, 1'b1, 32'hFFFF_FFFF, 33);
    do_op("rem_negdiv", rtype(7'b1, 3'b110, 5'd11), 32'd7, 32'hFFFF_FFFE, 32'h248, 5'd11, 1'b1, 32'd1, 33);
    do_op("divu_zero", rtype(7'b1, 3'b101, 5'd12), 32'h1234_5678, 32'h0, 32'h24C, 5'd12, 1'b1, 32'hFFFF_FFFF, 0);
    do_op("remu_zero", rtype(7'b1, 3'b111, 5'd12), 32'h1234_5678, 32'h0, 32'h250, 5'd12, 1'b1, 32'h1234_5678, 0);
    do_op("div_ovf", rtype(7'b1, 3'b100, 5'd13), 32'h8000_0000, 32'hFFFF_FFFF, 32'h254, 5'd13, 1'b1, 32'h8000_0000, 0);
    do_op("rem_ovf", rtype(7'b1, 3'b110, 5'd13), 32'h8000_0000, 32'hFFFF_FFFF, 32'h258, 5'd13, 1'b1, 32'h0, 0);
    do_op("illegal", 32'h0000_00FF, 32'd3, 32'd4, 32'h25C, 5'd14, 1'b0, 32'h0, 0);

    // Abort a divide with reset in its cycle 10.
    @(posedge clk); #1;
    inst_i = rtype(7'b1, 3'b100, 5'd15); op1_i = 32'hFFFF_FFF9; op2_i = 32'd2;
    instaddr_i = 32'h260; rd_addr_i = 5'd15; regs_wen_i = 1'b1;
    repeat (10) @(negedge clk);
    check("pre_reset_hold", {31'b0, hold_req_o}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0; inst_i = NOP; regs_wen_i = 1'b0;
    @(negedge clk);
    check("midreset_hold", {31'b0, hold_req_o}, 32'd0);
    check("midreset_wdata", rd_wdata_o, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_hold", {31'b0, hold_req_o}, 32'd0);
    do_op("add_after_reset", rtype(7'b0, 3'b000, 5'd2), 32'd3, 32'd4, 32'h264, 5'd2, 1'b1, 32'd7, 0);

    do_op("divu_a", rtype(7'b1, 3'b101, 5'd16), 32'd100, 32'd7, 32'h268, 5'd16, 1'b1, 32'd14, 33);
    do_op("divu_b", rtype(7'b1, 3'b101, 5'd17), 32'd100, 32'd9, 32'h26C, 5'd17, 1'b1, 32'd11, 33);

    @(posedge clk); #1;
    inst_i = NOP; regs_wen_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
